// File: rtl/nrzi_rx_decoder.sv
// rtl/nrzi_rx_decoder.sv - NRZI receive decoder: sync hunt, bit unstuffing, LSB-first word deserializer.
// Optional NRZI_RX_STATS_EN adds word_cnt/err_cnt wrapping 16-bit counters.
module nrzi_rx_decoder #(
  parameter int                  WIDTH     = 8,
  parameter int                  SYNC_LEN  = 8,
  parameter logic [SYNC_LEN-1:0] SYNC      = 'h80,
  parameter int                  STUFF_LEN = 6
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             line_en,
  input  logic             line_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             sync_det,
  output logic             frame_end,
  output logic             err
`ifdef NRZI_RX_STATS_EN
  ,
  output logic [15:0]      word_cnt,
  output logic [15:0]      err_cnt
`endif
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]      ONES_MAX = 4'(STUFF_LEN);

  typedef enum logic {HUNT, DATA} state_t;

  state_t              state_q, state_d;
  logic                prev_q, prev_d;
  logic [SYNC_LEN-2:0] sr_q, sr_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]          ones_q, ones_d;
  logic [WIDTH-1:0]    word_q, word_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                ov_q, ov_d, sd_q, sd_d, fe_q, fe_d, err_q, err_d;

  logic                dbit;
  logic [SYNC_LEN-1:0] window;

  // sr_q keeps the previous SYNC_LEN-1 bits; the current bit completes the window.
  assign dbit   = (line_in == prev_q);
  assign window = {dbit, sr_q};

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    word_d    = word_q;
    dout_d    = dout_q;
    ov_d      = 1'b0;
    sd_d      = 1'b0;
    fe_d      = 1'b0;
    err_d     = 1'b0;

    if (line_en) prev_d = line_in;

    case (state_q)
      HUNT: begin
        if (line_en) begin
          if (window == SYNC) begin
            sd_d      = 1'b1;
            state_d   = DATA;
            bit_cnt_d = '0;
            ones_d    = '0;
            sr_d      = '0;
          end else begin
            sr_d = window[SYNC_LEN-1:1];
          end
        end
      end
      DATA: begin
        if (!line_en) begin
          fe_d      = 1'b1;
          err_d     = (bit_cnt_q != '0);
          state_d   = HUNT;
          bit_cnt_d = '0;
          ones_d    = '0;
        end else if (ones_q == ONES_MAX) begin
          // A 0 here is the stuffed bit; a 1 breaks the stuffing rule.
          if (dbit) begin
            err_d     = 1'b1;
            state_d   = HUNT;
            bit_cnt_d = '0;
          end
          ones_d = '0;
        end else begin
          word_d[bit_cnt_q] = dbit;
          ones_d = dbit ? ones_q + 4'd1 : 4'd0;
          if (bit_cnt_q == LAST_BIT) begin
            dout_d    = word_d;
            ov_d      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= HUNT;
      prev_q    <= 1'b1;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      ones_q    <= '0;
      word_q    <= '0;
      dout_q    <= '0;
      ov_q      <= 1'b0;
      sd_q      <= 1'b0;
      fe_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      word_q    <= word_d;
      dout_q    <= dout_d;
      ov_q      <= ov_d;
      sd_q      <= sd_d;
      fe_q      <= fe_d;
      err_q     <= err_d;
    end
  end

  assign data_out  = dout_q;
  assign out_valid = ov_q;
  assign sync_det  = sd_q;
  assign frame_end = fe_q;
  assign err       = err_q;

`ifdef NRZI_RX_STATS_EN
  logic [15:0] word_cnt_q, err_cnt_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (ov_d)  word_cnt_q <= word_cnt_q + 16'd1;
      if (err_d) err_cnt_q  <= err_cnt_q + 16'd1;
    end
  end

  assign word_cnt = word_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// tb/tb_nrzi_rx_decoder.sv - scoreboard bench for nrzi_rx_decoder with directed NRZI vectors.
module tb_nrzi_rx_decoder;

  logic       clk = 1'b0;
  logic       areset;
  logic       line_en;
  logic       line_in;
  logic [7:0] data_out;
  logic       out_valid, sync_det, frame_end, err;
`ifdef NRZI_RX_STATS_EN
  logic [15:0] word_cnt, err_cnt;
`endif

  nrzi_rx_decoder dut (
    .clk       (clk),
    .areset    (areset),
    .line_en   (line_en),
    .line_in   (line_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .sync_det  (sync_det),
    .frame_end (frame_end),
    .err       (err)
`ifdef NRZI_RX_STATS_EN
    ,
    .word_cnt  (word_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ov;
    logic       sd;
    logic       fe;
    logic       er;
    logic [7:0] d;
  } ev_t;

  ev_t  exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   ov_t_last = 0;
  int   ov_t_prev = 0;
  logic tb_level;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe the DUT raises must match the oldest expected event.
  always @(negedge clk) begin
    if (!areset && (out_valid || sync_det || frame_end || err)) begin
      ev_t e;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: got ov=%0b sd=%0b fe=%0b err=%0b data=%02h, required no event",
                 out_valid, sync_det, frame_end, err, data_out);
      end else begin
        e = exp_q.pop_front();
        if ({out_valid, sync_det, frame_end, err} == {e.ov, e.sd, e.fe, e.er} &&
            (!e.ov || data_out == e.d)) begin
          n_pass++;
        end else begin
          $display("FAIL event: got ov=%0b sd=%0b fe=%0b err=%0b data=%02h, required ov=%0b sd=%0b fe=%0b err=%0b data=%02h",
                   out_valid, sync_det, frame_end, err, data_out, e.ov, e.sd, e.fe, e.er, e.d);
        end
      end
      if (out_valid) begin
        ov_t_prev = ov_t_last;
        ov_t_last = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic push(input logic ov, input logic sd, input logic fe, input logic er,
                      input logic [7:0] d);
    ev_t e;
    e.ov = ov; e.sd = sd; e.fe = fe; e.er = er; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic en, input logic lvl);
    @(negedge clk);
    line_en = en;
    line_in = lvl;
  endtask

  // Encoder model: decoded 0 toggles the line, decoded 1 holds it.
  task automatic send_dbit(input logic b);
    if (!b) tb_level = ~tb_level;
    drive(1'b1, tb_level);
  endtask

  task automatic send_sync();
    logic [7:0] s;
    s = 8'h80;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      send_dbit(s[i]);
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(1'b1, 1'b0, 1'b0, 1'b0, w);
      send_dbit(w[i]);
    end
  endtask

  task automatic end_frame(input logic partial);
    push(1'b0, 1'b0, 1'b1, partial, 8'h00);
    drive(1'b0, tb_level);
    drive(1'b0, tb_level);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"},  {8'h00, data_out}, 16'h0000);
    check({tag, "_out_valid"}, {15'h0, out_valid}, 16'h0000);
    check({tag, "_sync_det"},  {15'h0, sync_det},  16'h0000);
    check({tag, "_frame_end"}, {15'h0, frame_end}, 16'h0000);
    check({tag, "_err"},       {15'h0, err},       16'h0000);
  endtask

  initial begin
    logic [7:0] sync_lv;
    logic [7:0] word_lv;
    sync_lv = 8'b0010_1010;  // levels 0,1,0,1,0,1,0,0 first in bit 0
    word_lv = 8'b0011_0110;  // levels 0,1,1,0,1,1,0,0 first in bit 0

    areset   = 1'b1;
    line_en  = 1'b0;
    line_in  = 1'b1;
    tb_level = 1'b1;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
`ifdef NRZI_RX_STATS_EN
    check("reset_word_cnt", word_cnt, 16'h0000);
    check("reset_err_cnt",  err_cnt,  16'h0000);
`endif

    // Raw line levels: sync then 8'hA5, frame ends on a word boundary.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, sync_lv[i]);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
      drive(1'b1, word_lv[i]);
    end
    tb_level = 1'b0;
    end_frame(1'b0);

    // Six 1s, stuffed 0, two 1s -> 8'hFF.
    send_sync();
    for (int i = 0; i < 6; i++) send_dbit(1'b1);
    send_dbit(1'b0);
    send_dbit(1'b1);
    push(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    send_dbit(1'b1);
    end_frame(1'b0);

    // Seventh consecutive 1 is a stuff violation.
    send_sync();
    for (int i = 0; i < 6; i++) send_dbit(1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    send_dbit(1'b1);
    drive(1'b0, tb_level);
    drive(1'b0, tb_level);

    // Partial word at frame end.
    send_sync();
    send_dbit(1'b0);
    send_dbit(1'b1);
    send_dbit(1'b0);
    end_frame(1'b1);

    // Back-to-back words with no gap.
    send_sync();
    send_word(8'h3C);
    send_word(8'hC3);
    end_frame(1'b0);
    check("b2b_spacing", 16'(ov_t_last - ov_t_prev), 16'd8);

    // Async reset mid-word clears outputs before any clock edge.
    send_sync();
    send_dbit(1'b1);
    send_dbit(1'b0);
    send_dbit(1'b1);
    send_dbit(1'b0);
    @(negedge clk);
    #1;
    areset  = 1'b1;
    line_en = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    areset   = 1'b0;
    tb_level = 1'b1;
    send_sync();
    send_word(8'h5A);
    end_frame(1'b0);

    repeat (3) drive(1'b0, tb_level);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
`ifdef NRZI_RX_STATS_EN
    check("stats_word_cnt", word_cnt, 16'd1);
    check("stats_err_cnt",  err_cnt,  16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nrzi_rx_decoder.md
Name: nrzi_rx_decoder

Overview:
- Receive-side counterpart of the team's NRZI line encoder (encoder: data 0 toggles the line, data 1 holds it; line level resets high).
- Samples the serial NRZI line, recovers data bits, hunts for a sync pattern and removes stuffed bits.
- Deserializes the payload LSB-first into WIDTH-bit words with a single-cycle valid strobe.
- Sits between the line-sampling front end and the byte-level packet logic.

Parameters:
- WIDTH, 8, output word width in bits (2..16).
- SYNC_LEN, 8, sync pattern length in bits (2..16).
- SYNC, 8'h80, sync pattern in decoded bits; first-received bit in bit 0.
- STUFF_LEN, 6, consecutive decoded 1s after which one stuffed 0 follows (1..15).

Ports:
- clk  input  1  clock; all logic on rising edge.
- areset  input  1  asynchronous active-high reset.
- line_en  input  1  line_in holds a valid bit this cycle. Low means idle or end of frame.
- line_in  input  1  sampled NRZI line level.
- data_out  output  WIDTH  recovered word, LSB = first payload bit received.
- out_valid  output  1  one-cycle strobe; data_out valid.
- sync_det  output  1  one-cycle strobe; sync matched, frame started.
- frame_end  output  1  one-cycle strobe; line_en dropped while in DATA.
- err  output  1  one-cycle strobe; stuff violation or partial word at frame end.

Behaviour:
- Reset is areset, asynchronous, active-high; clock is clk.
- Reset values:
  - prev_level = 1.
  - state = HUNT.
  - sync shift register, bit counter and ones counter all 0.
  - data_out = 0; out_valid, sync_det, frame_end and err all 0.
- Decode: in a cycle with line_en=1, dbit = 1 if line_in == prev_level, else 0. prev_level <= line_in on every line_en=1 cycle, in every state.
- prev_level holds while line_en=0.
- All outputs are registered. Strobes rise in the cycle after the clk edge that sampled the triggering bit, and last exactly one cycle.
- State HUNT:
  - Each line_en bit shifts dbit into an SYNC_LEN-bit shift register at the MSB end, so after SYNC_LEN bits the first bit sits in bit 0.
  - On match with SYNC: pulse sync_det, go to DATA, clear bit counter, ones counter and shift register.
  - line_en=0 in HUNT: no action and no strobes.
- State DATA, each line_en bit:
  - Ones counter == STUFF_LEN and dbit=0: stuffed bit. Drop it and clear the ones counter.
  - Ones counter == STUFF_LEN and dbit=1: stuff violation. Pulse err, discard the partial word, go to HUNT.
  - Otherwise: the bit is payload. Write it into word[bit_cnt] and increment bit_cnt. Increment the ones counter if dbit=1, else clear it.
  - When bit_cnt reaches WIDTH: data_out <= assembled word, pulse out_valid, bit_cnt <= 0. The stream continues with no gap cycle required.
- line_en=0 while in DATA:
  - Pulse frame_end and go to HUNT.
  - If bit_cnt != 0, also pulse err and discard the partial word.
  - Ones counter is cleared.
- Simultaneous events: the completing bit and stuff-counter logic act on the same edge. A word completed by the sixth 1 is emitted; the following bit must be the stuffed 0.
- data_out holds its last value between strobes.
- areset mid-frame: immediate return to reset values; no strobes are emitted.

Optional Feature:
- Macro NRZI_RX_STATS_EN.
- Defined:
  - Adds output ports word_cnt (16) and err_cnt (16), both reset to 0.
  - word_cnt increments on each out_valid; err_cnt increments on each err.
  - Both wrap at 16'hFFFF -> 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Sync and single byte: after reset, line_en=1 with line levels 0,1,0,1,0,1,0,0 -> sync_det pulses after the 8th bit. Then levels 0,1,1,0,1,1,0,0 -> out_valid pulse with data_out=8'hA5.
- Bit unstuffing: after sync, decoded bits 1,1,1,1,1,1,0(stuffed),1,1 -> exactly one out_valid with data_out=8'hFF; err stays 0.
- Stuff violation: after sync, seven consecutive decoded 1s -> err pulse after the 7th bit, state returns to HUNT, no out_valid.
- Partial frame: after sync, 3 payload bits then line_en=0 -> frame_end and err pulse in the same cycle, no out_valid. A full 8-bit frame ending on a word boundary gives frame_end with err=0.
- Back-to-back words: after sync, 16 payload bits encoding 8'h3C then 8'hC3 -> two out_valid pulses exactly 8 line_en cycles apart, with the correct values.
- Async reset mid-word: assert areset after 4 payload bits -> all outputs 0 immediately. The next sync plus 8'h5A decodes correctly, with prev_level restarting at 1. With NRZI_RX_STATS_EN defined, word_cnt counts 1 after this.
